// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: sequences sample/settle/decide for the fuzzy irrigation
// datapath and times the valve run with rain abort, manual stop and cooldown.
module irrigation_scheduler #(
    parameter int CLK_PER_SEC     = 50_000_000,
    parameter int SAMPLE_PERIOD_S = 60,
    parameter int SETTLE_CYCLES   = 4,
    parameter int MAX_IRRIG_S     = 120,
    parameter int COOLDOWN_S      = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        manual_start,
    input  logic        manual_stop,
    input  logic [7:0]  irrigation_time,
    input  logic        rain_present,
    output logic        sample_strobe,
    output logic        valve_on,
    output logic        busy,
    output logic [2:0]  state,
    output logic [7:0]  remaining_s,
    output logic [15:0] cycle_count,
    output logic        rain_abort
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SAMPLE   = 3'd1,
        S_SETTLE   = 3'd2,
        S_DECIDE   = 3'd3,
        S_IRRIGATE = 3'd4,
        S_COOLDOWN = 3'd5
    } state_e;

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(CLK_PER_SEC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [15:0]   SAMPLE_LAST = 16'(SAMPLE_PERIOD_S - 1);
    localparam logic [15:0]   COOL_LAST   = 16'(COOLDOWN_S - 1);
    localparam logic [7:0]    MAX_DUR     = 8'(MAX_IRRIG_S);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   sec_q, sec_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [7:0]    remaining_d;
    logic [15:0]   count_d;
    logic          abort_d;
    logic [7:0]    dur;
    logic          sec_tick;
    logic          timing_clear;

    assign sec_tick = (presc_q == PRESC_LAST);
    assign dur      = (irrigation_time > MAX_DUR) ? MAX_DUR : irrigation_time;
    assign state    = state_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        remaining_d = remaining_s;
        count_d     = cycle_count;
        abort_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && (manual_start || (sec_tick && sec_q == SAMPLE_LAST)))
                    state_d = S_SAMPLE;
            end
            S_SAMPLE: state_d = S_SETTLE;
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST)
                    state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (rain_present || dur == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    remaining_d = dur;
                    state_d     = S_IRRIGATE;
                end
            end
            S_IRRIGATE: begin
                if (manual_stop) begin
                    remaining_d = 8'd0;
                    state_d     = S_COOLDOWN;
                end else if (rain_present) begin
                    remaining_d = 8'd0;
                    abort_d     = 1'b1;
                    state_d     = S_COOLDOWN;
                end else if (sec_tick) begin
                    if (remaining_s == 8'd1) begin
                        remaining_d = 8'd0;
                        count_d     = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
                        state_d     = S_COOLDOWN;
                    end else begin
                        remaining_d = remaining_s - 8'd1;
                    end
                end
            end
            S_COOLDOWN: begin
                if (sec_tick && sec_q == COOL_LAST)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Disable overrides every other exit and abandons the run without credit.
        if (!enable && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            remaining_d = 8'd0;
            count_d     = cycle_count;
            abort_d     = 1'b0;
        end

        // Timers restart on each transition so every state duration is exact.
        timing_clear = (state_d != state_q) || !enable;
        presc_d      = (timing_clear || sec_tick) ? '0 : presc_q + PW'(1);
        sec_d        = timing_clear ? 16'd0 : (sec_tick ? sec_q + 16'd1 : sec_q);
        settle_d     = (timing_clear || state_q != S_SETTLE) ? '0 : settle_q + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            sec_q         <= 16'd0;
            settle_q      <= '0;
            remaining_s   <= 8'd0;
            cycle_count   <= 16'd0;
            sample_strobe <= 1'b0;
            valve_on      <= 1'b0;
            busy          <= 1'b0;
            rain_abort    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all registers see the same pre-edge values.
            state_q       <= state_d;
            presc_q       <= presc_d;
            sec_q         <= sec_d;
            settle_q      <= settle_d;
            remaining_s   <= remaining_d;
            cycle_count   <= count_d;
            sample_strobe <= (state_d == S_SAMPLE);
            valve_on      <= (state_d == S_IRRIGATE);
            busy          <= (state_d != S_IDLE);
            rain_abort    <= abort_d;
        end
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler: stimulus pushes the expected profile of each evaluation
// run; an independent monitor measures the run the DUT performs and compares.
module tb_irrigation_scheduler;

    localparam int CPS    = 4;
    localparam int SP     = 3;
    localparam int SETTLE = 2;
    localparam int MAXI   = 120;
    localparam int COOL   = 2;

    typedef enum int {EX_NONE, EX_STOP, EX_RAIN, EX_BOTH} exit_e;
    typedef struct {
        int idle;
        int irr;
        int cool;
        int rem_first;
        int aborts;
        int cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, enable, manual_start, manual_stop, rain_present;
    logic [7:0]  irrigation_time;
    logic        sample_strobe, valve_on, busy, rain_abort;
    logic [2:0]  state;
    logic [7:0]  remaining_s;
    logic [15:0] cycle_count;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_cnt = 0;
    bit   mon_on = 1'b1;

    irrigation_scheduler #(
        .CLK_PER_SEC(CPS), .SAMPLE_PERIOD_S(SP), .SETTLE_CYCLES(SETTLE),
        .MAX_IRRIG_S(MAXI), .COOLDOWN_S(COOL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .manual_start(manual_start),
        .manual_stop(manual_stop), .irrigation_time(irrigation_time),
        .rain_present(rain_present), .sample_strobe(sample_strobe),
        .valve_on(valve_on), .busy(busy), .state(state), .remaining_s(remaining_s),
        .cycle_count(cycle_count), .rain_abort(rain_abort)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run profile derived directly from the scheduling rules.
    function automatic exp_t model(int t, bit r, exit_e kind, int k, int idle);
        exp_t e;
        int   dur;
        dur         = (t > MAXI) ? MAXI : t;
        e.idle      = idle;
        e.irr       = 0;
        e.cool      = 0;
        e.rem_first = 0;
        e.aborts    = 0;
        if (!r && dur > 0) begin
            e.rem_first = dur;
            e.cool      = COOL * CPS;
            if (kind == EX_NONE) begin
                e.irr = dur * CPS;
                if (model_cnt < 65535) model_cnt++;
            end else begin
                e.irr    = k + 1;
                e.aborts = (kind == EX_RAIN) ? 1 : 0;
            end
        end
        e.cnt = model_cnt;
        return e;
    endfunction

    // Called mid-cycle 0 of IDLE; returns mid-cycle 0 of the following IDLE.
    task automatic run_txn(int t, bit r, exit_e kind, int k, bit manual, int m);
        int dur, n;
        dur = (t > MAXI) ? MAXI : t;
        exp_q.push_back(model(t, r, (r || dur == 0) ? EX_NONE : kind, k, manual ? m + 1 : SP * CPS));
        irrigation_time = 8'(t);
        rain_present    = r;
        if (manual) begin
            repeat (m) @(negedge clk);
            manual_start = 1'b1;
            @(negedge clk);
            manual_start = 1'b0;
        end
        n = 0;
        while (!busy && n < 64) begin @(negedge clk); n++; end
        check("run_started", int'(busy), 1);
        if (!r && dur > 0 && kind != EX_NONE) begin
            n = 0;
            while (!valve_on && n < 64) begin @(negedge clk); n++; end
            check("valve_rise", int'(valve_on), 1);
            repeat (k) @(negedge clk);
            check("remaining_before_exit", int'(remaining_s), dur - k / CPS);
            manual_stop  = (kind == EX_STOP || kind == EX_BOTH);
            rain_present = (kind == EX_RAIN || kind == EX_BOTH);
            @(negedge clk);
            manual_stop  = 1'b0;
            rain_present = 1'b0;
        end
        n = 0;
        while (busy && n < 1200) begin @(negedge clk); n++; end
        check("run_ended", int'(busy), 0);
        rain_present = 1'b0;
    endtask

    int  idle_cnt = 1, bad_inv = 0;
    int  r_idle, r_sample, r_settle, r_decide, r_irr, r_cool, r_rem_first, r_rem_end;
    int  r_aborts, r_abort_entry;
    bit  in_run = 1'b0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                in_run   = 1'b0;
                idle_cnt = 1;
                continue;
            end
            if ((valve_on != (state == 3'd4)) || (busy != (state != 3'd0)) ||
                (sample_strobe != (state == 3'd1)))
                bad_inv++;
            if (state == 3'd0) begin
                if (in_run) begin
                    in_run = 1'b0;
                    if (mon_on) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL sb_unexpected_run: got a run, expected none queued");
                        end else begin
                            e = exp_q.pop_front();
                            check("idle_cycles", r_idle, e.idle);
                            check("sample_cycles", r_sample, 1);
                            check("settle_cycles", r_settle, SETTLE);
                            check("decide_cycles", r_decide, 1);
                            check("valve_cycles", r_irr, e.irr);
                            check("cooldown_cycles", r_cool, e.cool);
                            check("remaining_at_start", r_rem_first, e.rem_first);
                            check("remaining_at_cooldown", r_rem_end, 0);
                            check("rain_abort_pulses", r_aborts, e.aborts);
                            check("rain_abort_at_entry", r_abort_entry, e.aborts);
                            check("cycle_count", int'(cycle_count), e.cnt);
                            check("output_consistency", bad_inv, 0);
                        end
                    end
                    bad_inv  = 0;
                    idle_cnt = 1;
                end else begin
                    idle_cnt++;
                end
            end else begin
                if (!in_run) begin
                    in_run = 1'b1;
                    r_idle = idle_cnt;
                    r_sample = 0; r_settle = 0; r_decide = 0; r_irr = 0; r_cool = 0;
                    r_rem_first = 0; r_rem_end = 0; r_aborts = 0; r_abort_entry = 0;
                end
                r_aborts += int'(rain_abort);
                case (state)
                    3'd1: r_sample++;
                    3'd2: r_settle++;
                    3'd3: r_decide++;
                    3'd4: begin
                        if (r_irr == 0) r_rem_first = int'(remaining_s);
                        r_irr++;
                    end
                    3'd5: begin
                        if (r_cool == 0) begin
                            r_rem_end     = int'(remaining_s);
                            r_abort_entry = int'(rain_abort);
                        end
                        r_cool++;
                    end
                    default: bad_inv++;
                endcase
            end
        end
    end

    initial begin : stimulus
        int n, t, dur;
        exit_e kind;
        reset = 1'b1; enable = 1'b1; manual_start = 1'b0; manual_stop = 1'b0;
        rain_present = 1'b0; irrigation_time = 8'd10;
        repeat (3) @(negedge clk);
        check("reset_state", int'(state), 0);
        check("reset_outputs", int'({sample_strobe, valve_on, busy, rain_abort}), 0);
        reset = 1'b0;

        run_txn(10, 0, EX_NONE, 0, 0, 0);
        run_txn(200, 0, EX_NONE, 0, 1, 0);
        run_txn(10, 0, EX_RAIN, 20, 1, 5);
        run_txn(50, 1, EX_NONE, 0, 1, 2);
        run_txn(0, 0, EX_NONE, 0, 0, 0);
        run_txn(20, 0, EX_STOP, 7, 0, 0);
        run_txn(20, 0, EX_BOTH, 13, 1, 3);
        run_txn(1, 0, EX_NONE, 0, 1, 11);
        run_txn(3, 0, EX_STOP, 11, 1, 0);
        run_txn(3, 0, EX_RAIN, 0, 1, 0);
        run_txn(121, 0, EX_NONE, 0, 1, 1);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 9))
                0:       t = 0;
                1:       t = int'($urandom_range(121, 255));
                default: t = int'($urandom_range(1, 40));
            endcase
            dur  = (t > MAXI) ? MAXI : t;
            kind = exit_e'($urandom_range(0, 3));
            n    = (dur > 0) ? int'($urandom_range(0, dur * CPS - 1)) : 0;
            run_txn(t, ($urandom_range(0, 5) == 0), kind, n,
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 11)));
        end

        mon_on = 1'b0;
        irrigation_time = 8'd2;
        manual_start = 1'b1;
        @(negedge clk);
        manual_start = 1'b0;
        n = 0;
        while (state != 3'd5 && n < 200) begin @(negedge clk); n++; end
        check("reach_cooldown", int'(state), 5);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("disable_state", int'(state), 0);
        check("disable_busy", int'(busy), 0);
        manual_start = 1'b1;
        @(negedge clk);
        manual_start = 1'b0;
        repeat (20) @(negedge clk);
        check("disabled_ignores_start", int'(busy), 0);
        irrigation_time = 8'd0;
        enable = 1'b1;
        n = 0;
        while (!sample_strobe && n < 50) begin @(negedge clk); n++; end
        check("enable_resume_strobe", n, SP * CPS);
        n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        check("zero_run_idle", int'(busy), 0);

        irrigation_time = 8'd5;
        manual_start = 1'b1;
        @(negedge clk);
        manual_start = 1'b0;
        n = 0;
        while (!valve_on && n < 64) begin @(negedge clk); n++; end
        check("valve_before_reset", int'(valve_on), 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valve", int'(valve_on), 0);
        check("async_reset_state", int'(state), 0);
        check("async_reset_flags", int'({sample_strobe, busy, rain_abort}), 0);
        check("async_reset_remaining", int'(remaining_s), 0);
        check("async_reset_count", int'(cycle_count), 0);
        @(negedge clk);
        reset = 1'b0;
        manual_start = 1'b1;
        @(negedge clk);
        manual_start = 1'b0;
        check("start_after_reset", int'(sample_strobe), 1);
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        check("final_idle", int'(busy), 0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/irrigation_scheduler.md
# irrigation_scheduler

Sequencing controller for the fuzzy irrigation datapath. It periodically strobes the sensor front-end to capture soil, temperature and rain samples, then waits for the fuzzy inference result to settle. It reads the resulting `irrigation_time` and `rain_present`, and drives the valve for that many seconds, with rain abort, a manual override and a post-irrigation cooldown. It sits between the fuzzification/inference block and the valve driver.

## Interface
Parameters:
- `CLK_PER_SEC`, 50_000_000: clock cycles per second; sets the second prescaler terminal count.
- `SAMPLE_PERIOD_S`, 60: seconds spent in IDLE before an automatic evaluation.
- `SETTLE_CYCLES`, 4: cycles between `sample_strobe` and reading the fuzzy outputs. Must be ≥1.
- `MAX_IRRIG_S`, 120: cap on the irrigation duration, in seconds (≤255).
- `COOLDOWN_S`, 30: seconds the valve is held off after every irrigation run.

Ports:
- `clk` in 1: system clock. One clock domain; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: scheduler enable. When low, forces IDLE.
- `manual_start` in 1: single-cycle request for an immediate evaluation. Honoured only in IDLE.
- `manual_stop` in 1: single-cycle request to end irrigation early.
- `irrigation_time` in 8: fuzzy result, in seconds.
- `rain_present` in 1: rain flag from the fuzzy block.
- `sample_strobe` out 1: one-cycle capture pulse to the sensor front-end.
- `valve_on` out 1: valve drive.
- `busy` out 1: high whenever the state is not IDLE.
- `state` out 3: current state code.
- `remaining_s` out 8: seconds left in the current irrigation run.
- `cycle_count` out 16: number of completed irrigation runs. Saturates at 16'hFFFF.
- `rain_abort` out 1: one-cycle pulse when rain ends a run.

## Operation
State codes: IDLE=0, SAMPLE=1, SETTLE=2, DECIDE=3, IRRIGATE=4, COOLDOWN=5. Codes 6 and 7 go to IDLE.

Timing primitives:
- A prescaler counts 0..CLK_PER_SEC-1. `sec_tick` is asserted when the prescaler is at CLK_PER_SEC-1.
- The prescaler and the seconds counter both clear on every state transition, so durations are exact.

State behaviour:
- IDLE:
  - While `enable`=0, stay in IDLE with the counters held at 0.
  - With `enable`=1, `manual_start`=1 goes to SAMPLE on the next edge.
  - Otherwise, go to SAMPLE after SAMPLE_PERIOD_S seconds.
- SAMPLE: lasts one cycle with `sample_strobe`=1, then goes to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to DECIDE.
- DECIDE: lasts one cycle. Computes dur = min(`irrigation_time`, MAX_IRRIG_S).
  - If `rain_present`=1 or dur=0, go to IDLE.
  - Otherwise load `remaining_s`=dur and go to IRRIGATE.
- IRRIGATE:
  - Each `sec_tick` decrements `remaining_s`.
  - When a `sec_tick` arrives with `remaining_s`=1, `remaining_s` becomes 0, `cycle_count` increments and the state goes to COOLDOWN.
- COOLDOWN: lasts COOLDOWN_S seconds, then goes to IDLE. `manual_start` is ignored here.

Early exits from IRRIGATE, highest priority first (all take effect on the same edge):
1. `enable`=0 in any non-IDLE state goes to IDLE.
2. `manual_stop`=1 goes to COOLDOWN.
3. `rain_present`=1 goes to COOLDOWN and `rain_abort` pulses.
4. Normal expiry as described under IRRIGATE.

Early exits do not increment `cycle_count` and clear `remaining_s` to 0. `manual_stop` outside IRRIGATE is ignored.

Arithmetic rules:
- The dur comparison is 8-bit unsigned.
- `cycle_count` increments saturate rather than wrap.

## Timing
- Reset values: state IDLE, and `sample_strobe`, `valve_on`, `busy`, `remaining_s`, `cycle_count` and `rain_abort` all 0. The prescaler and counters are also 0.
- Asserting `reset` mid-run drops `valve_on` asynchronously, with no cooldown.
- All outputs are registered. `valve_on`=1 exactly while state=IRRIGATE, for dur×CLK_PER_SEC cycles on normal expiry.
- Automatic sample timing: `sample_strobe` is high on cycle SAMPLE_PERIOD_S×CLK_PER_SEC after IDLE entry (cycle 0 is the first cycle in IDLE).
- `manual_start` sampled high in IDLE makes `sample_strobe` high on the following cycle.
- The inputs `irrigation_time` and `rain_present` are sampled only in the DECIDE cycle, which is SETTLE_CYCLES+1 cycles after `sample_strobe`. The exception is that `rain_present` is also monitored every cycle during IRRIGATE.
- `rain_abort` and the IRRIGATE→COOLDOWN transition occur on the same edge. `valve_on` is low from that edge onward.

## Test plan
Unless stated otherwise, the bench uses CLK_PER_SEC=4, SAMPLE_PERIOD_S=3, SETTLE_CYCLES=2, COOLDOWN_S=2 and `enable`=1.

1. Release reset with `irrigation_time`=10 and `rain_present`=0.
   - Required: `sample_strobe` is high on cycle 12; DECIDE is on cycle 15; `valve_on` is high for 40 cycles; COOLDOWN lasts 8 cycles; `cycle_count`=1; the state returns to IDLE.
2. Drive `irrigation_time`=200 with MAX_IRRIG_S=120.
   - Required: `remaining_s` loads 120 and the valve is high for 480 cycles.
3. During IRRIGATE with `remaining_s`=5, raise `rain_present`.
   - Required: a one-cycle `rain_abort`; `valve_on` goes 0; the state goes to COOLDOWN; `remaining_s`=0; `cycle_count` is unchanged.
4. At DECIDE, drive `rain_present`=1 in one run and `irrigation_time`=0 in another.
   - Required: `valve_on` never asserts, the state goes back to IDLE, and the next strobe comes 12 cycles later.
5. During IRRIGATE, assert `manual_stop` in one run; in a separate run, assert `manual_stop` and `rain_present` together.
   - Required: both go to COOLDOWN, and `rain_abort` stays 0 in the simultaneous case.
   - Also drop `enable` mid-COOLDOWN. Required: IDLE on the next edge and `busy`=0.
6. Assert `reset` mid-IRRIGATE.
   - Required: all outputs are 0 asynchronously; after release, `manual_start` produces a strobe on the next cycle.
